absdiff_unpack: RTL

ABSDIFF_UNPACK -- requirements
Module: absdiff_unpack

---
 rtl/absdiff_unpack.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/absdiff_unpack.sv
// Decodes an (|a-b|, max(a,b), relation) record back into operands a and b.
// The smaller operand is recovered by a bit-serial subtraction taking 8 clocks.
module absdiff_unpack (
   input  logic       clk,
   input  logic       RESET_N,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_result,
   input  logic [7:0] in_temp,
   input  logic [1:0] in_rel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   output logic       out_eq,
   output logic       out_err
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [1:0] REL_GT = 2'b01;
   localparam logic [1:0] REL_LT = 2'b10;
   localparam logic [1:0] REL_EQ = 2'b11;

   state_t     state;
   state_t     next_state;

   logic [7:0] res_q;
   logic [7:0] tmp_q;
   logic [1:0] rel_q;
   logic [7:0] min_sr;
   logic [2:0] cnt;
   logic       borrow;

   logic       accept;
   logic       last_bit;
   logic       drain;
   logic       r_bit;
   logic       t_bit;
   logic       diff_bit;
   logic       borrow_next;
   logic [7:0] min_full;

   logic [7:0] dec_a;
   logic [7:0] dec_b;
   logic       dec_eq;
   logic       dec_err;

   assign accept   = (state == IDLE) && in_valid && in_ready;
   assign last_bit = (state == CALC) && (cnt == 3'd7);
   assign drain    = (state == DONE) && out_ready;

   // One full-subtractor slice of temp - result, walking LSB to MSB.
   assign r_bit       = res_q[cnt];
   assign t_bit       = tmp_q[cnt];
   assign diff_bit    = t_bit ^ r_bit ^ borrow;
   assign borrow_next = (~t_bit & (r_bit | borrow)) | (t_bit & r_bit & borrow);
   assign min_full    = {diff_bit, min_sr[7:1]};

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)   next_state = CALC;
         CALC:    if (last_bit) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         res_q  <= 8'h00;
         tmp_q  <= 8'h00;
         rel_q  <= 2'b00;
         min_sr <= 8'h00;
         cnt    <= 3'd0;
         borrow <= 1'b0;
      end else if (accept) begin
         res_q  <= in_result;
         tmp_q  <= in_temp;
         rel_q  <= in_rel;
         min_sr <= 8'h00;
         cnt    <= 3'd0;
         borrow <= 1'b0;
      end else if (state == CALC) begin
         min_sr <= min_full;
         cnt    <= cnt + 3'd1;
         borrow <= borrow_next;
      end
   end

   // Final decode uses the last difference bit and borrow straight from the slice.
   always_comb begin
      dec_a   = 8'h00;
      dec_b   = 8'h00;
      dec_eq  = 1'b0;
      dec_err = 1'b1;
      case (rel_q)
         REL_GT: begin
            dec_a   = tmp_q;
            dec_b   = min_full;
            dec_err = borrow_next;
         end
         REL_LT: begin
            dec_a   = min_full;
            dec_b   = tmp_q;
            dec_err = borrow_next;
         end
         REL_EQ: begin
            dec_eq  = 1'b1;
            dec_err = !((tmp_q == 8'hFF) && (res_q == 8'hFF));
         end
         default: begin
            dec_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_a     <= 8'h00;
         out_b     <= 8'h00;
         out_eq    <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         in_ready <= (next_state == IDLE);
         if (last_bit) begin
            out_valid <= 1'b1;
            out_a     <= dec_a;
            out_b     <= dec_b;
            out_eq    <= dec_eq;
            out_err   <= dec_err;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
